// File: rtl/pwm_channel_bank.sv
// PWM engine: prescaled phase counter drives NUM_CHANNELS ON/OFF-compare outputs, with shadow
// registers reloaded only at period boundaries. Optional output inversion: PWM_OUTPUT_INVERT_EN.
module pwm_channel_bank #(
    parameter int NUM_CHANNELS  = 16,
    parameter int COUNTER_WIDTH = 12,
    parameter int PRESCALE_MIN  = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [0:2047]            register_blob_i,
    input  logic                     sleep_i,
    output logic [NUM_CHANNELS-1:0]  pwm_o,
    output logic                     period_start_o,
    output logic [COUNTER_WIDTH-1:0] counter_o
);
    localparam int            CW      = COUNTER_WIDTH;
    localparam int            PRE_BIT = 8 * 254;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [7:0]    PRE_MIN = 8'(PRESCALE_MIN);

    logic [7:0]              presc_q, presc_d;
    logic [7:0]              pre_q;
    logic [7:0]              p_eff;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    load_pending_q, load_pending_d;
    logic                    period_start_q, period_start_d;
    logic [NUM_CHANNELS-1:0] pwm_q, pwm_d;
    logic [NUM_CHANNELS-1:0] hit;
    logic                    inv_q;
    logic                    tick, wrap, load;
    logic                    blob_unused;

    // Only a handful of blob bytes are decoded; the rest is deliberately left dangling.
    assign blob_unused = ^register_blob_i;

    // The raw PRE byte is shadowed and clamped on use, so the reset value still gives a sane rate.
    assign p_eff = (pre_q < PRE_MIN) ? PRE_MIN : pre_q;
    assign tick  = (presc_q >= p_eff);
    assign wrap  = tick && (cnt_q == CNT_MAX);
    assign load  = !sleep_i && (wrap || load_pending_q);

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        localparam int B = 8 * (6 + 4 * gi);
        logic [CW-1:0] on_q, off_q;
        logic          full_on_q, full_off_q;
        logic          level;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                on_q       <= '0;
                off_q      <= '0;
                full_on_q  <= 1'b0;
                full_off_q <= 1'b0;
            end else if (load) begin
                on_q       <= CW'({register_blob_i[B+12 +: 4], register_blob_i[B +: 8]});
                full_on_q  <= register_blob_i[B+11];
                off_q      <= CW'({register_blob_i[B+28 +: 4], register_blob_i[B+16 +: 8]});
                full_off_q <= register_blob_i[B+27];
            end
        end

        always_comb begin
            level = 1'b0;
            if (full_off_q) begin
                level = 1'b0;
            end else if (full_on_q) begin
                level = 1'b1;
            end else if (on_q == off_q) begin
                level = 1'b0;
            end else if (on_q < off_q) begin
                level = (cnt_q >= on_q) && (cnt_q < off_q);
            end else begin
                level = (cnt_q >= on_q) || (cnt_q < off_q);
            end
        end

        assign hit[gi] = level;
    end

`ifdef PWM_OUTPUT_INVERT_EN
    localparam int INVRT_BIT = 8 * 1 + 3;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inv_q <= 1'b0;
        end else if (load) begin
            inv_q <= register_blob_i[INVRT_BIT];
        end
    end
`else
    assign inv_q = 1'b0;
`endif

    always_comb begin
        presc_d        = tick ? 8'd0 : presc_q + 8'd1;
        cnt_d          = tick ? cnt_q + CW'(1) : cnt_q;
        period_start_d = wrap;
        load_pending_d = 1'b0;
        pwm_d          = hit ^ {NUM_CHANNELS{inv_q}};
        // Sleep parks everything at phase 0 and arms a reload for the first awake clock.
        if (sleep_i) begin
            presc_d        = 8'd0;
            cnt_d          = '0;
            period_start_d = 1'b0;
            load_pending_d = 1'b1;
            pwm_d          = {NUM_CHANNELS{inv_q}};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q        <= 8'd0;
            cnt_q          <= '0;
            pre_q          <= 8'd0;
            load_pending_q <= 1'b1;
            period_start_q <= 1'b0;
            pwm_q          <= '0;
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            load_pending_q <= load_pending_d;
            period_start_q <= period_start_d;
            pwm_q          <= pwm_d;
            if (load) begin
                pre_q <= register_blob_i[PRE_BIT +: 8];
            end
        end
    end

    assign pwm_o          = pwm_q;
    assign period_start_o = period_start_q;
    assign counter_o      = cnt_q;

endmodule

// File: doc/pwm_channel_bank.md
Name: pwm_channel_bank

Overview:
- Parametrised PWM engine for the PCA9685-compatible register map. Reads the shared 256-byte register blob written by the I2C target and drives NUM_CHANNELS PWM outputs.
- Free-running prescaled phase counter; per-channel ON/OFF compare with wrap-around.
- Shadow registers are reloaded only at period boundaries, so I2C writes never glitch an output mid-period.
- Sits beside the I2C target and register store in the top level; its outputs go to pins.

Parameters:
- NUM_CHANNELS, 16, number of PWM channels (1..16); channel n uses bytes 0x06+4n..0x09+4n.
- COUNTER_WIDTH, 12, phase counter width (4..12). Compare values use the low COUNTER_WIDTH bits of the 12-bit ON/OFF fields.
- PRESCALE_MIN, 3, minimum effective prescale; smaller register values are clamped up to this.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- register_blob_i  in  2048  register image [0:2047]; byte k = bits [8k:8k+7], bit 8k is MSB
- sleep_i  in  1  high = oscillator off: counter held, outputs low
- pwm_o  out  NUM_CHANNELS  registered PWM outputs
- period_start_o  out  1  one-cycle pulse when counter wraps to 0
- counter_o  out  COUNTER_WIDTH  current phase count

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - prescale counter, phase counter, all shadows, pwm_o, period_start_o all cleared to 0.
  - load_pending is set.
  - Reset mid-period aborts immediately.
- Register fields per channel n:
  - ON = {byte(7+4n)[3:0], byte(6+4n)}; FULL_ON = byte(7+4n)[4].
  - OFF = {byte(9+4n)[3:0], byte(8+4n)}; FULL_OFF = byte(9+4n)[4].
  - PRE = byte(0xFE); effective prescale P = max(PRE, PRESCALE_MIN).
- Tick: prescale counter counts 0..P, then returns to 0 and asserts tick. Tick period is P+1 clocks.
- Phase counter: increments on tick and wraps from 2^COUNTER_WIDTH-1 to 0.
- Shadow load: all channel fields and P are captured from register_blob_i on the same edge where either:
  - the phase counter wraps to 0, or
  - load_pending is set with rst_i=0 and sleep_i=0 (load_pending then clears).
- Register changes between loads have no effect on the outputs.
- period_start_o: registered, high for exactly the one cycle after the wrap edge. It does not pulse on the load_pending load.
- Channel output function f(c), evaluated in priority order:
  - FULL_OFF → 0
  - else FULL_ON → 1
  - else ON==OFF → 0
  - else ON<OFF → (ON ≤ c < OFF)
  - else (ON>OFF, wrap case) → (c ≥ ON) or (c < OFF)
  - The function uses shadow values.
- Latency: pwm_o[n] at cycle t+1 = f(counter_o at cycle t). Fixed 1-clock lag, identical for all channels.
- Sleep (sleep_i=1):
  - prescale and phase counters are forced to 0 and pwm_o to 0; no period_start_o pulse.
  - load_pending is set, so shadows reload on the first clock after sleep_i deasserts.
- Simultaneous events:
  - rst_i overrides sleep_i; sleep_i overrides tick.
  - A wrap edge and a register write in the same cycle: the blob value sampled at that edge is captured.
- Channels at index ≥ NUM_CHANNELS are ignored and their bytes are never read.

Optional Feature:
- Macro PWM_OUTPUT_INVERT_EN.
- Defined: MODE2 byte 0x01 bit4 (INVRT), shadow-loaded with the channel fields, XORs every pwm_o bit. While sleeping, outputs equal INVRT as most recently loaded into the shadow.
- Undefined: INVRT is ignored and the 0x01 byte is not read.

Test Plan:
- Reset then PRE=0x03, ch0 ON=0, OFF=2048 → tick every 4 clocks, period 16384 clocks; pwm_o[0] high 8192 clocks, low 8192 clocks; period_start_o pulses once per 16384 clocks.
- PRE=0x00 → clamped to P=3, period still 16384 clocks.
- ch1 ON=4000, OFF=100 → pwm_o[1] high for counts 4000..4095 and 0..99 (196 ticks) with 1-clock lag.
- ch2 FULL_ON=1 → constant 1. Then FULL_ON=1 and FULL_OFF=1 → constant 0 from the next period. ch3 ON=OFF=500 → constant 0.
- Change ch0 OFF from 2048 to 1024 at count 1500 → current period still ends high-to-low at 2048; next period ends at 1024.
- Assert rst_i at count 3000 with outputs high → next cycle pwm_o=0 and counter_o=0. Then assert sleep_i for 100 clocks → counter held at 0, pwm_o=0, no pulse, shadows reloaded on release. With PWM_OUTPUT_INVERT_EN and INVRT=1, all polarities invert.
